// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Holds the architectural PC and fetches one instruction at a time for it.
//   The PC advances only when decode accepts the instruction fetched from the
//   current PC; the new value always comes from the external next-PC mux.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   next_pc           next PC from the next-PC mux
//   pc_ena            mux enable, high only in the decode accept cycle
//   curr_pc           current PC, constant except on an accept edge
//   imem_req_*        fetch request handshake (valid/ready/addr)
//   imem_rsp_*        instruction return (single-cycle valid pulse + data)
//   inst_valid/ready  handshake towards decode, inst carries the word
//   fetch_err         sticky: a misaligned next_pc was presented at accept
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int unsigned             CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0]    RESET_PC  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] next_pc,
  output logic                 pc_ena,
  output logic [CPU_WIDTH-1:0] curr_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem_rsp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic                 fetch_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   pc_aligned;
  logic   rsp_take;

  assign imem_req_addr = curr_pc;
  assign pc_aligned    = (next_pc[1:0] == 2'b00);

  // Next-state and Moore/Mealy outputs.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    pc_ena         = 1'b0;
    accept         = 1'b0;
    rsp_take       = 1'b0;

    case (state)
      IDLE: state_nxt = REQ;

      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = WAIT;
      end

      // A response is only meaningful here; in every other state it is dropped,
      // which also discards a late response from a request abandoned by reset.
      WAIT: begin
        if (imem_rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          accept    = 1'b1;
          pc_ena    = 1'b1;
          state_nxt = pc_aligned ? REQ : ERR;
        end
      end

      ERR: state_nxt = ERR;

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      curr_pc   <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rsp_take)              inst      <= imem_rsp_data;
      if (accept && pc_aligned)  curr_pc   <= next_pc;
      if (accept && !pc_aligned) fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//   Directed bench for pc_fetch. Inputs are driven 1 ns after the rising edge,
//   outputs are checked 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] next_pc;
  logic         pc_ena;
  logic [W-1:0] curr_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst;
  logic         fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch #(.CPU_WIDTH(W), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .pc_ena         (pc_ena),
    .curr_pc        (curr_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .fetch_err      (fetch_err)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // One complete fetch starting in REQ with memory always ready and the
  // response one cycle after the request handshake. Decode stalls for
  // hold_cycles before accepting. Returns 1 ns after the accept edge.
  task automatic fetch_one(input logic [W-1:0] exp_addr, input logic [W-1:0] data,
                           input logic [W-1:0] nxt, input int hold_cycles);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    settle();
    check("req_valid@REQ", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr@REQ",  imem_req_addr, exp_addr);
    check("curr_pc@REQ",   curr_pc, exp_addr);
    check("pc_ena@REQ",    {31'b0, pc_ena}, 32'd0);
    check("inst_valid@REQ", {31'b0, inst_valid}, 32'd0);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    settle();
    check("req_valid@WAIT",  {31'b0, imem_req_valid}, 32'd0);
    check("inst_valid@WAIT", {31'b0, inst_valid}, 32'd0);
    cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    next_pc        = nxt;
    for (int i = 0; i < hold_cycles; i++) begin
      settle();
      check("inst_valid@stall", {31'b0, inst_valid}, 32'd1);
      check("inst@stall",       inst, data);
      check("pc_ena@stall",     {31'b0, pc_ena}, 32'd0);
      check("req_valid@stall",  {31'b0, imem_req_valid}, 32'd0);
      cyc();
    end
    inst_ready = 1'b1;
    settle();
    check("inst_valid@accept", {31'b0, inst_valid}, 32'd1);
    check("inst@accept",       inst, data);
    check("pc_ena@accept",     {31'b0, pc_ena}, 32'd1);
    check("curr_pc@accept",    curr_pc, exp_addr);
    cyc();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    next_pc        = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;

    // Reset state.
    cyc();
    cyc();
    check("rst curr_pc",    curr_pc, 32'h8000_0000);
    check("rst inst",       inst, 32'h0);
    check("rst fetch_err",  {31'b0, fetch_err}, 32'd0);
    check("rst req_valid",  {31'b0, imem_req_valid}, 32'd0);
    check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst pc_ena",     {31'b0, pc_ena}, 32'd0);

    // IDLE for exactly one cycle after reset releases.
    rst = 1'b0;
    settle();
    check("idle req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc();

    // Memory not ready for 5 cycles; a stray response in REQ must be dropped.
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("stall req_addr",  imem_req_addr, 32'h8000_0000);
      check("stall inst",      inst, 32'h0);
      cyc();
    end

    // Sequential stream 8000_0000 -> 04 -> 08, three cycles each when
    // decode is ready; the second instruction sees 4 stall cycles in HOLD.
    fetch_one(32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 0);
    fetch_one(32'h8000_0004, 32'h1111_1111, 32'h8000_0008, 4);
    check("pc_ena after accept", {31'b0, pc_ena}, 32'd0);

    // Misaligned next_pc at accept: sticky error, PC frozen, no further fetch.
    fetch_one(32'h8000_0008, 32'h2222_2222, 32'h8000_0102, 0);
    inst_ready     = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("err fetch_err",  {31'b0, fetch_err}, 32'd1);
      check("err curr_pc",    curr_pc, 32'h8000_0008);
      check("err req_valid",  {31'b0, imem_req_valid}, 32'd0);
      check("err inst_valid", {31'b0, inst_valid}, 32'd0);
      check("err pc_ena",     {31'b0, pc_ena}, 32'd0);
      check("err inst",       inst, 32'h2222_2222);
      cyc();
    end
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;

    // Reset clears the error.
    rst = 1'b1;
    cyc();
    check("rst2 fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst2 curr_pc",   curr_pc, 32'h8000_0000);
    rst = 1'b0;
    cyc();  // IDLE -> REQ

    // Reset while WAIT; the late response arrives in IDLE and in REQ.
    imem_req_ready = 1'b1;
    settle();
    check("pre-wait req_valid", {31'b0, imem_req_valid}, 32'd1);
    cyc();  // now WAIT
    rst = 1'b1;
    settle();
    check("async rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("async rst inst",      inst, 32'h0);
    cyc();
    rst            = 1'b0;  // IDLE for this cycle
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();                  // REQ, response coincides with the handshake
    settle();
    check("late rsp req_addr", imem_req_addr, 32'h8000_0000);
    check("late rsp inst",     inst, 32'h0);
    cyc();                  // WAIT, response pulse has already gone
    imem_rsp_valid = 1'b0;
    settle();
    check("dropped rsp inst_valid", {31'b0, inst_valid}, 32'd0);
    // Finish this fetch by hand, then branch to the top of the address space.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_0001;
    cyc();
    imem_rsp_valid = 1'b0;
    next_pc        = 32'hFFFF_FFFC;
    inst_ready     = 1'b1;
    settle();
    check("post-rst inst",   inst, 32'hCAFE_0001);
    check("post-rst pc_ena", {31'b0, pc_ena}, 32'd1);
    cyc();
    inst_ready = 1'b0;

    // Wrap from FFFF_FFFC to 0000_0000 via next_pc.
    fetch_one(32'hFFFF_FFFC, 32'h3333_3333, 32'h0000_0000, 0);
    fetch_one(32'h0000_0000, 32'h4444_4444, 32'h0000_0004, 0);
    settle();
    check("wrap fetch_err", {31'b0, fetch_err}, 32'd0);
    check("wrap req_addr",  imem_req_addr, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
